// File: rtl/decoder_xx6812.sv
// xx6812 one-wire stream decoder: measures synchronized high widths to
// recover bits, captures the first 24-bit word after each latch gap and
// forwards the rest of the frame downstream.
module decoder_xx6812 #(
  parameter int HIGH_THRESHOLD = 7,
  parameter int MAX_HIGH       = 20,
  parameter int RESET_CYCLES   = 600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_data_in,
  output logic [23:0] parallel_data_out,
  output logic        data_valid,
  output logic        frame_end,
  output logic        error,
  output logic        serial_data_out
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;

  localparam logic [7:0]  HI_THR = 8'(HIGH_THRESHOLD);
  localparam logic [7:0]  HI_MAX = 8'(MAX_HIGH);
  localparam logic [7:0]  HI_SAT = 8'(MAX_HIGH + 1);
  localparam logic [15:0] LO_GAP = 16'(RESET_CYCLES);

  // Saturating increments keep long pulses and long gaps from wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, s_q, s_d, sdly_q, sdly_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] low_q, low_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic [23:0] pout_q, pout_d;
  logic        dv_q, dv_d, fe_q, fe_d, err_q, err_d, fwd_q, fwd_d;
  logic        new_bit, rise;

  assign rise = s_q & ~sdly_q;

  // Next-state, counters, word assembly and output pulses.
  always_comb begin
    sync1_d  = serial_data_in;
    s_d      = sync1_q;
    sdly_d   = s_q;
    state_d  = state_q;
    high_d   = high_q;
    low_d    = low_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    pout_d   = pout_q;
    fwd_d    = fwd_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    err_d    = 1'b0;
    new_bit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = 8'd1;
        end
      end
      HIGH: begin
        if (high_q > HI_MAX) begin
          err_d    = 1'b1;
          state_d  = ERROR;
          bitcnt_d = '0;
          shreg_d  = '0;
          low_d    = '0;
        end else if (!s_q) begin
          new_bit = (high_q >= HI_THR);
          shreg_d = {shreg_q[22:0], new_bit};
          low_d   = 16'd1;
          state_d = LOW;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            if (!fwd_q) begin
              pout_d = {shreg_q[22:0], new_bit};
              dv_d   = 1'b1;
              fwd_d  = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else begin
          high_d = sat_inc8(high_q, HI_SAT);
        end
      end
      LOW: begin
        if (low_q >= LO_GAP) begin
          fe_d     = 1'b1;
          state_d  = IDLE;
          bitcnt_d = '0;
          shreg_d  = '0;
          fwd_d    = 1'b0;
          low_d    = '0;
          high_d   = '0;
        end else if (rise) begin
          state_d = HIGH;
          high_d  = 8'd1;
        end else if (!s_q) begin
          low_d = sat_inc16(low_q);
        end
      end
      default: begin  // ERROR: wait for a full latch gap
        if (low_q >= LO_GAP) begin
          fe_d     = 1'b1;
          state_d  = IDLE;
          bitcnt_d = '0;
          shreg_d  = '0;
          fwd_d    = 1'b0;
          low_d    = '0;
          high_d   = '0;
        end else if (s_q) begin
          low_d = '0;
        end else begin
          low_d = sat_inc16(low_q);
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      sdly_q   <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      pout_q   <= '0;
      fwd_q    <= 1'b0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      sdly_q   <= sdly_d;
      high_q   <= high_d;
      low_q    <= low_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      pout_q   <= pout_d;
      fwd_q    <= fwd_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      err_q    <= err_d;
    end
  end

  assign parallel_data_out = pout_q;
  assign data_valid        = dv_q;
  assign frame_end         = fe_q;
  assign error             = err_q;
  assign serial_data_out   = s_q & fwd_q;

endmodule

// File: tb/tb_decoder_xx6812.sv
// Directed bench for decoder_xx6812: words, forwarding, gaps, errors, reset.
module tb_decoder_xx6812;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        serial_data_in = 1'b0;
  logic [23:0] parallel_data_out;
  logic        data_valid, frame_end, error, serial_data_out;

  decoder_xx6812 dut (
    .clock(clock),
    .reset(reset),
    .serial_data_in(serial_data_in),
    .parallel_data_out(parallel_data_out),
    .data_valid(data_valid),
    .frame_end(frame_end),
    .error(error),
    .serial_data_out(serial_data_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  int dv_cnt = 0, fe_cnt = 0, err_cnt = 0, sdo_ones = 0, fwd_err = 0, consec = 0;
  logic chk_fwd = 1'b0;
  logic [1:0] hist = 2'b00;
  logic pdv = 1'b0, pfe = 1'b0, perr = 1'b0;

  // Input history, sampled on the same edge as the DUT synchronizer.
  always @(posedge clock) hist <= {hist[0], serial_data_in};

  // Output monitor on the inactive edge.
  always @(negedge clock) begin
    if (data_valid) dv_cnt++;
    if (frame_end) fe_cnt++;
    if (error) err_cnt++;
    if (serial_data_out) sdo_ones++;
    if ((data_valid && pdv) || (frame_end && pfe) || (error && perr)) consec++;
    if (chk_fwd && (serial_data_out !== hist[1])) fwd_err++;
    pdv  = data_valid;
    pfe  = frame_end;
    perr = error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_data_in = 1'b1;
    tick(b ? 10 : 5);
    serial_data_in = 1'b0;
    tick(b ? 5 : 10);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[23-i]);
  endtask

  task automatic gap();
    serial_data_in = 1'b0;
    tick(620);
  endtask

  initial begin
    tick(3);
    check("rst_dout", parallel_data_out, 0);
    check("rst_dv", data_valid, 0);
    check("rst_fe", frame_end, 0);
    check("rst_err", error, 0);
    check("rst_sdo", serial_data_out, 0);
    reset = 1'b1;
    tick(3);

    // First word after reset is captured, nothing forwarded.
    sdo_ones = 0;
    send_word(24'hA5C3F0, 24);
    check("w1_dout", parallel_data_out, 32'hA5C3F0);
    check("w1_dv", dv_cnt, 1);
    check("w1_sdo_quiet", sdo_ones, 0);

    // Second word in same frame is forwarded, not captured.
    chk_fwd = 1'b1;
    send_word(24'h123456, 24);
    chk_fwd = 1'b0;
    check("fwd_match", fwd_err, 0);
    check("fwd_active", (sdo_ones > 0), 1);
    check("w2_dout", parallel_data_out, 32'hA5C3F0);
    check("w2_dv", dv_cnt, 1);

    // Latch gap, then new word.
    gap();
    check("gap1_fe", fe_cnt, 1);
    check("gap1_sdo", serial_data_out, 0);
    send_word(24'h00FF00, 24);
    check("w3_dout", parallel_data_out, 32'h00FF00);
    check("w3_dv", dv_cnt, 2);

    // Partial word discarded at a gap.
    gap();
    send_word(24'hFEDCBA, 12);
    gap();
    check("part_fe", fe_cnt, 3);
    check("part_dv", dv_cnt, 2);
    check("part_dout", parallel_data_out, 32'h00FF00);
    send_word(24'h5A5A5A, 24);
    check("w4_dout", parallel_data_out, 32'h5A5A5A);
    check("w4_dv", dv_cnt, 3);

    // Over-long high pulse, bits ignored until a gap.
    gap();
    serial_data_in = 1'b1;
    tick(25);
    serial_data_in = 1'b0;
    tick(10);
    check("err_pulse", err_cnt, 1);
    send_word(24'hABCDEF, 24);
    check("err_ign_err", err_cnt, 1);
    check("err_ign_dv", dv_cnt, 3);
    check("err_ign_dout", parallel_data_out, 32'h5A5A5A);
    gap();
    check("err_gap_fe", fe_cnt, 5);
    send_word(24'h3C3C3C, 24);
    check("w5_dout", parallel_data_out, 32'h3C3C3C);
    check("w5_dv", dv_cnt, 4);

    // Reset in the middle of a word.
    gap();
    send_word(24'h0F0F0F, 10);
    reset = 1'b0;
    serial_data_in = 1'b0;
    #1;
    check("mid_rst_dout", parallel_data_out, 0);
    check("mid_rst_dv", data_valid, 0);
    check("mid_rst_fe", frame_end, 0);
    check("mid_rst_err", error, 0);
    check("mid_rst_sdo", serial_data_out, 0);
    tick(3);
    reset = 1'b1;
    tick(3);
    check("mid_rst_no_dv", dv_cnt, 4);
    send_word(24'hFFFFFF, 24);
    check("w6_dout", parallel_data_out, 32'hFFFFFF);
    check("w6_dv", dv_cnt, 5);
    check("fe_total", fe_cnt, 6);
    check("pulse_width", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_xx6812.md
DECODER_XX6812 -- requirements
Module: decoder_xx6812

Interface
REQ-001 SHALL have parameter HIGH_THRESHOLD, default 7: min synchronized high width (clock cycles) decoded as bit 1.
REQ-002 SHALL have parameter MAX_HIGH, default 20: longest legal high width (cycles); longer is a protocol error.
REQ-003 SHALL have parameter RESET_CYCLES, default 600: continuous low cycles recognised as latch/reset gap (50 us at 12 MHz).
REQ-004 SHALL have port clock  input  1  single system clock, rising-edge, all state in this domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port serial_data_in  input  1  xx6812 one-wire stream (asynchronous to clock).
REQ-007 SHALL have port parallel_data_out  output  24  last complete word, bit 23 = first bit received.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when parallel_data_out is updated.
REQ-009 SHALL have port frame_end  output  1  one-cycle pulse when a latch gap is recognised.
REQ-010 SHALL have port error  output  1  one-cycle pulse when a high pulse exceeds MAX_HIGH.
REQ-011 SHALL have port serial_data_out  output  1  downstream stream, forwarded after own word captured.

Function
REQ-012 SHALL pass serial_data_in through a 2-flop synchronizer; all decoding uses the synchronized signal s and its registered copy s_d.
REQ-013 SHALL implement states IDLE, HIGH, LOW, ERROR.
REQ-014 IDLE: SHALL go to HIGH on rising edge of s (s_d=0, s=1), high counter loaded with 1.
REQ-015 HIGH: SHALL increment high counter each cycle s=1, saturating at MAX_HIGH+1 (8-bit counter).
REQ-016 HIGH: SHALL on falling edge decode bit = 1 if high count >= HIGH_THRESHOLD else 0, shift it in MSB-first, increment bit count, go LOW with low counter = 1.
REQ-017 HIGH: SHALL, when high count exceeds MAX_HIGH, pulse error next cycle, discard the partial word, go ERROR.
REQ-018 LOW: SHALL go HIGH on rising edge; increment low counter (16-bit, saturating) while s=0.
REQ-019 LOW/ERROR: SHALL, when low count reaches RESET_CYCLES, pulse frame_end next cycle, clear bit count and shift register, clear forwarding, go IDLE.
REQ-020 ERROR: SHALL ignore all edges; only a full latch gap exits it (low counter restarts on every rising edge).
REQ-021 SHALL, on decoding the 24th bit of a word, update parallel_data_out and pulse data_valid in the cycle after the falling edge, reset bit count to 0, and set forwarding.
REQ-022 SHALL capture only the first word after each latch gap; later bits in the same frame SHALL NOT change parallel_data_out or pulse data_valid.
REQ-023 SHALL drive serial_data_out = s while forwarding is set, else 0; the 24th bit of own word is never forwarded.
REQ-024 SHALL discard a partial word (<24 bits) at a latch gap; parallel_data_out holds its previous value.
REQ-025 SHALL treat a gap between bits shorter than RESET_CYCLES as inter-bit low, no timeout.
REQ-026 data_valid, frame_end, error SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 SHALL on reset=0 asynchronously force: state IDLE, parallel_data_out 0, data_valid 0, frame_end 0, error 0, serial_data_out 0, forwarding 0, all counters and synchronizer 0.
REQ-028 SHALL after reset release treat the line as already latched (IDLE), accepting the first word without a preceding gap.
REQ-029 Reset asserted mid-word SHALL discard the partial word; no data_valid pulse results.

Verification
REQ-030 Reset release, 24 bits of 0xA5C3F0 (T0H 5, T1H 10 cycles, period 15) -> parallel_data_out=0xA5C3F0, exactly one data_valid pulse, serial_data_out stays 0.
REQ-031 Continue with word 0x123456 in same frame -> serial_data_out equals serial_data_in delayed 2 cycles, parallel_data_out stays 0xA5C3F0, no data_valid.
REQ-032 Hold line low 600 cycles -> one frame_end pulse, serial_data_out 0; next word 0x00FF00 -> parallel_data_out=0x00FF00.
REQ-033 Send 12 bits then 600-cycle low -> frame_end pulse, no data_valid, parallel_data_out unchanged; next 24 bits decoded correctly.
REQ-034 High pulse of 25 cycles -> one error pulse; further bits ignored until 600-cycle low, then frame_end and normal decoding.
REQ-035 Assert reset after 10 bits of a word -> all outputs 0 immediately; after release, fresh 24-bit word 0xFFFFFF decoded correctly.
